// File: rtl/display_manager_if.sv
// Handshake and display bundle for display_manager.
// master = word source / observer, slave = display_manager.
interface display_manager_if;
   logic [15:0] data_2;
   logic        data_2_valid;
   logic [2:0]  prog;
   logic [1:0]  modules;
   logic        busy;
   logic        parity;
   logic [7:0]  an;
   logic [7:0]  dec_ddp;

   modport master (
      output data_2,
      output data_2_valid,
      output prog,
      output modules,
      input  busy,
      input  parity,
      input  an,
      input  dec_ddp
   );

   modport slave (
      input  data_2,
      input  data_2_valid,
      input  prog,
      input  modules,
      output busy,
      output parity,
      output an,
      output dec_ddp
   );
endinterface

// File: rtl/display_manager.sv
// Binary-to-BCD conversion and 8-digit seven-segment scan.
// Newest word arriving during a conversion wins.
module display_manager #(
   parameter int REFRESH_DIV = 100000,
   parameter int CNT_W       = 17
) (
   input logic              clk,
   input logic              rst,
   display_manager_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } state_t;

   state_t       state_q;
   logic [15:0]  bin_q;
   logic [15:0]  word_q;
   logic [19:0]  bcd_q;
   logic [4:0]   iter_q;
   logic [15:0]  pend_word_q;
   logic         pend_q;
   logic [19:0]  disp_q;
   logic         busy_q;
   logic         parity_q;

   logic [19:0]  bcd_adj;
   logic [19:0]  bcd_nxt;
   logic [15:0]  bin_nxt;
   logic [15:0]  next_word;

   logic [CNT_W-1:0] cnt_q;
   logic [2:0]       idx_q;
   logic [7:0]       an_q;
   logic [7:0]       dec_q;
   logic [6:0]       seg_sel;
   logic             dp_sel;

   logic [3:0] d0;
   logic [3:0] d1;
   logic [3:0] d2;
   logic [3:0] d3;
   logic [3:0] d4;
   logic       blank1;
   logic       blank2;
   logic       blank3;
   logic       blank4;

   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'b0000001;
         4'd1:    s = 7'b1001111;
         4'd2:    s = 7'b0010010;
         4'd3:    s = 7'b0000110;
         4'd4:    s = 7'b1001100;
         4'd5:    s = 7'b0100100;
         4'd6:    s = 7'b0100000;
         4'd7:    s = 7'b0001111;
         4'd8:    s = 7'b0000000;
         4'd9:    s = 7'b0000100;
         default: s = 7'b1111111;
      endcase
      return s;
   endfunction

   // Add-3 correction on every nibble, then one left shift of {bcd, bin}.
   always_comb begin
      bcd_adj = bcd_q;
      for (int i = 0; i < 5; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
      bcd_nxt = {bcd_adj[18:0], bin_q[15]};
      bin_nxt = {bin_q[14:0], 1'b0};
   end

   // A valid in DONE beats the stored pending word: it is newer.
   always_comb begin
      next_word = pend_word_q;
      if (bus.data_2_valid) begin
         next_word = bus.data_2;
      end
   end

   // Conversion FSM with registered busy, parity and display value.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         bin_q       <= '0;
         word_q      <= '0;
         bcd_q       <= '0;
         iter_q      <= '0;
         pend_word_q <= '0;
         pend_q      <= 1'b0;
         disp_q      <= '0;
         busy_q      <= 1'b0;
         parity_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.data_2_valid) begin
                  bin_q   <= bus.data_2;
                  word_q  <= bus.data_2;
                  bcd_q   <= '0;
                  iter_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end
            end
            SHIFT: begin
               if (bus.data_2_valid) begin
                  pend_word_q <= bus.data_2;
                  pend_q      <= 1'b1;
               end
               bcd_q  <= bcd_nxt;
               bin_q  <= bin_nxt;
               iter_q <= iter_q + 5'd1;
               if (iter_q == 5'd15) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               disp_q   <= bcd_q;
               parity_q <= ^word_q;
               if (bus.data_2_valid || pend_q) begin
                  bin_q   <= next_word;
                  word_q  <= next_word;
                  bcd_q   <= '0;
                  iter_q  <= '0;
                  pend_q  <= 1'b0;
                  state_q <= SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   // Refresh counter and scan index.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         idx_q <= '0;
      end else if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
         cnt_q <= '0;
         idx_q <= idx_q + 3'd1;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign d0 = disp_q[3:0];
   assign d1 = disp_q[7:4];
   assign d2 = disp_q[11:8];
   assign d3 = disp_q[15:12];
   assign d4 = disp_q[19:16];

   assign blank4 = (d4 == 4'd0);
   assign blank3 = blank4 && (d3 == 4'd0);
   assign blank2 = blank3 && (d2 == 4'd0);
   assign blank1 = blank2 && (d1 == 4'd0);

   // Segment pattern for the digit currently selected.
   always_comb begin
      seg_sel = 7'b1111111;
      dp_sel  = 1'b1;
      unique case (idx_q)
         3'd0: seg_sel = seg7(d0);
         3'd1: seg_sel = blank1 ? 7'b1111111 : seg7(d1);
         3'd2: seg_sel = blank2 ? 7'b1111111 : seg7(d2);
         3'd3: seg_sel = blank3 ? 7'b1111111 : seg7(d3);
         3'd4: seg_sel = blank4 ? 7'b1111111 : seg7(d4);
         3'd5: seg_sel = 7'b1111111;
         3'd6: begin
            unique case (bus.modules)
               2'd1:    seg_sel = 7'b0111000;
               2'd2:    seg_sel = 7'b1110000;
               2'd3:    seg_sel = 7'b0110000;
               default: seg_sel = 7'b1111111;
            endcase
         end
         3'd7: begin
            seg_sel = seg7({1'b0, bus.prog});
            dp_sel  = 1'b0;
         end
         default: seg_sel = 7'b1111111;
      endcase
   end

   // Enable and segments register together so they never skew.
   always_ff @(posedge clk) begin
      if (rst) begin
         an_q  <= 8'hFF;
         dec_q <= 8'hFF;
      end else begin
         an_q  <= ~(8'd1 << idx_q);
         dec_q <= {seg_sel, dp_sel};
      end
   end

   assign bus.busy    = busy_q;
   assign bus.parity  = parity_q;
   assign bus.an      = an_q;
   assign bus.dec_ddp = dec_q;

endmodule

// File: tb/tb_display_manager.sv
// Self-checking bench for display_manager.
// Randomised words against an arithmetic display model.
module tb_display_manager;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   display_manager_if bus ();

   display_manager #(
      .REFRESH_DIV(4),
      .CNT_W(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [6:0] seg_tbl [0:9] = '{
      7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
      7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
   };

   function automatic logic [7:0] exp_code(input int idx, input int val,
                                           input logic [1:0] m,
                                           input logic [2:0] p);
      int pw;
      int digit;
      pw = 1;
      for (int i = 0; i < idx; i++) pw = pw * 10;
      if (idx < 5) begin
         digit = (val / pw) % 10;
         if (idx > 0 && val < pw) return 8'hFF;
         return {seg_tbl[digit], 1'b1};
      end
      if (idx == 5) return 8'hFF;
      if (idx == 6) begin
         case (m)
            2'd1:    return {7'b0111000, 1'b1};
            2'd2:    return {7'b1110000, 1'b1};
            2'd3:    return {7'b0110000, 1'b1};
            default: return 8'hFF;
         endcase
      end
      return {seg_tbl[p], 1'b0};
   endfunction

   function automatic logic exp_parity(input int val);
      return logic'($countones(val[15:0]) % 2);
   endfunction

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic pulse(input logic [15:0] w);
      bus.data_2       = w;
      bus.data_2_valid = 1'b1;
      tick();
      bus.data_2_valid = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (bus.busy === 1'b1 && n < 60) begin
         tick();
         n++;
      end
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL %s idle-timeout busy=%b want=0", name, bus.busy);
      end
   endtask

   task automatic check_display(input string name, input int val);
      logic [7:0] got [8];
      bit         seen [8];
      int         nseen;
      logic [7:0] want;
      for (int k = 0; k < 8; k++) seen[k] = 1'b0;
      nseen = 0;
      for (int c = 0; c < 48 && nseen < 8; c++) begin
         tick();
         for (int k = 0; k < 8; k++) begin
            if (bus.an == 8'(~(8'd1 << k)) && !seen[k]) begin
               seen[k] = 1'b1;
               got[k]  = bus.dec_ddp;
               nseen++;
            end
         end
      end
      for (int k = 0; k < 8; k++) begin
         total++;
         want = exp_code(k, val, bus.modules, bus.prog);
         if (!seen[k]) begin
            bad++;
            $display("FAIL %s digit%0d never-scanned want=%b", name, k, want);
         end else if (got[k] !== want) begin
            bad++;
            $display("FAIL %s digit%0d got=%b want=%b", name, k, got[k], want);
         end
      end
   endtask

   task automatic check_parity(input string name, input int val);
      total++;
      if (bus.parity !== exp_parity(val)) begin
         bad++;
         $display("FAIL %s parity got=%b want=%b", name, bus.parity,
                  exp_parity(val));
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      total += 4;
      if (bus.an !== 8'hFF) begin
         bad++;
         $display("FAIL reset_an got=%h want=ff", bus.an);
      end
      if (bus.dec_ddp !== 8'hFF) begin
         bad++;
         $display("FAIL reset_dec got=%h want=ff", bus.dec_ddp);
      end
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL reset_busy got=%b want=0", bus.busy);
      end
      if (bus.parity !== 1'b0) begin
         bad++;
         $display("FAIL reset_parity got=%b want=0", bus.parity);
      end
      rst = 1'b0;
   endtask

   task automatic test_scan();
      logic [7:0] want;
      do_reset();
      for (int k = 1; k <= 36; k++) begin
         tick();
         want = 8'(~(8'd1 << (((k - 1) / 4) % 8)));
         total++;
         if (bus.an !== want) begin
            bad++;
            $display("FAIL scan_an cycle%0d got=%h want=%h", k, bus.an, want);
         end
      end
      check_display("scan_zero", 0);
   endtask

   task automatic test_max();
      int n;
      pulse(16'hFFFF);
      n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      total++;
      if (n != 17) begin
         bad++;
         $display("FAIL max_busy_len got=%0d want=17", n);
      end
      check_parity("max", 65535);
      check_display("max", 65535);
   endtask

   task automatic test_blanking();
      pulse(16'd7);
      wait_idle("blank");
      check_parity("blank", 7);
      check_display("blank", 7);
   endtask

   task automatic test_labels();
      bus.modules = 2'd2;
      bus.prog    = 3'd5;
      check_display("labels_t", 7);
      bus.modules = 2'd1;
      check_display("labels_f", 7);
      bus.modules = 2'd3;
      bus.prog    = 3'd0;
      check_display("labels_e", 7);
   endtask

   task automatic test_random();
      int w;
      for (int r = 0; r < 8; r++) begin
         w           = int'($urandom_range(0, 65535));
         bus.modules = 2'($urandom_range(0, 3));
         bus.prog    = 3'($urandom_range(0, 7));
         pulse(16'(w));
         wait_idle("rand");
         check_parity("rand", w);
         check_display("rand", w);
      end
   endtask

   task automatic test_back_to_back();
      bit dropped;
      int t;
      bus.modules = 2'd0;
      bus.prog    = 3'd0;
      pulse(16'hFFFF);
      wait_idle("b2b_pre");
      bus.data_2       = 16'd1234;
      bus.data_2_valid = 1'b1;
      dropped = 1'b0;
      for (t = 1; t <= 33; t++) begin
         tick();
         bus.data_2_valid = 1'b0;
         if (t == 5) begin
            bus.data_2       = 16'd42;
            bus.data_2_valid = 1'b1;
         end
         if (t == 8) begin
            bus.data_2       = 16'd999;
            bus.data_2_valid = 1'b1;
         end
         if (bus.busy !== 1'b1) dropped = 1'b1;
         if (t == 17) check_parity("b2b_before_first", 65535);
         if (t == 18) check_parity("b2b_first_1234", 1234);
      end
      total++;
      if (dropped) begin
         bad++;
         $display("FAIL b2b_busy_gap got=dropped want=continuous");
      end
      for (int k = 0; k < 4 && bus.busy === 1'b1; k++) tick();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL b2b_busy_end got=%b want=0", bus.busy);
      end
      check_parity("b2b_last", 999);
      check_display("b2b_last", 999);
   endtask

   task automatic test_reset_mid();
      bus.data_2       = 16'd500;
      bus.data_2_valid = 1'b1;
      for (int t = 1; t <= 6; t++) begin
         tick();
         bus.data_2_valid = 1'b0;
      end
      rst = 1'b1;
      tick();
      total += 3;
      if (bus.an !== 8'hFF) begin
         bad++;
         $display("FAIL midrst_an got=%h want=ff", bus.an);
      end
      if (bus.dec_ddp !== 8'hFF) begin
         bad++;
         $display("FAIL midrst_dec got=%h want=ff", bus.dec_ddp);
      end
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL midrst_busy got=%b want=0", bus.busy);
      end
      rst = 1'b0;
      for (int t = 0; t < 20; t++) tick();
      total++;
      if (bus.busy !== 1'b0) begin
         bad++;
         $display("FAIL midrst_restart got=%b want=0", bus.busy);
      end
      check_parity("midrst", 0);
      check_display("midrst", 0);
   endtask

   initial begin
      total            = 0;
      bad              = 0;
      rst              = 1'b1;
      bus.data_2       = '0;
      bus.data_2_valid = 1'b0;
      bus.prog         = '0;
      bus.modules      = '0;
      test_reset();
      test_scan();
      test_max();
      test_blanking();
      test_labels();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
